// File: rtl/sat_pkg.sv
// Shared types and sizing for the SAT unit-clause path: literal encoding,
// arbiter state encoding and literal field helpers.
package sat_pkg;
  localparam int NUM_ENGINE  = 4;
  localparam int NUM_VARS    = 64;
  localparam int UCQ_DEPTH   = 8;
  localparam int STACK_DEPTH = 64;
  localparam int VAR_W       = $clog2(NUM_VARS);
  localparam int LIT_W       = VAR_W + 1;

  // Literal = {sign, var}; sign 1 means the variable is negated.
  typedef logic [LIT_W-1:0] lit_t;

  typedef enum logic [2:0] {
    UCA_IDLE,
    UCA_CHECK,
    UCA_BCAST,
    UCA_CONFLICT,
    UCA_DONE
  } uca_state_e;

  function automatic logic [VAR_W-1:0] lit_var(input lit_t l);
    return l[VAR_W-1:0];
  endfunction

  function automatic logic lit_sign(input lit_t l);
    return l[LIT_W-1];
  endfunction
endpackage

// File: rtl/uc_fifo.sv
// Small synchronous FIFO with wrap-bit pointers, a flush that drops all
// contents, and a sticky overflow flag for writes attempted while full.
module uc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q;
  logic [PW:0]      rd_ptr_q;
  logic             overflow_q;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign rd_data_o  = mem_q[rd_ptr_q[PW-1:0]];
  assign overflow_o = overflow_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_i && full_o) overflow_q <= 1'b1;
      // A flush wins over a same-cycle write so nothing slips in behind it.
      if (flush_i) begin
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (wr_en_i && !full_o) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
        if (rd_en_i && !empty_o) rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !full_o && !flush_i) mem_q[wr_ptr_q[PW-1:0]] <= wr_data_i;
  end
endmodule

// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: checks queued unit literals against the assignment
// table, broadcasts new assignments to all engines and logs them on a stack.
module uc_arbiter
  import sat_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  halt,
  input  lit_t                  mem2uca,
  input  logic                  mem2uca_valid,
  input  logic                  mem2uca_done,
  output logic                  ucq_full,
  output logic                  ucq_overflow,
  output lit_t                  bcast_lit,
  output logic                  bcast_valid,
  input  logic [NUM_ENGINE-1:0] eng_ack,
  output logic                  conflict,
  output logic                  uca_done,
  input  logic                  mstack_pop,
  output logic                  mstack_empty,
  output lit_t                  mstack_lit
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  uca_state_e            state_q, state_d;
  lit_t                  lit_q, lit_d;
  logic [NUM_ENGINE-1:0] ack_mask_q, ack_mask_d;
  logic                  done_seen_q;
  logic [NUM_VARS-1:0]   assigned_q;
  logic [NUM_VARS-1:0]   value_q;
  lit_t                  stack_q [STACK_DEPTH];
  logic [SP_W-1:0]       sp_q;
  lit_t                  mstack_lit_q;
  logic [SP_W-2:0]       below_idx;

  logic fifo_rd, fifo_flush, fifo_empty;
  lit_t fifo_head;
  logic push, pop;

  uc_fifo #(.WIDTH(LIT_W), .DEPTH(UCQ_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (mem2uca_valid),
    .wr_data_i  (mem2uca),
    .rd_en_i    (fifo_rd),
    .flush_i    (fifo_flush),
    .rd_data_o  (fifo_head),
    .full_o     (ucq_full),
    .empty_o    (fifo_empty),
    .overflow_o (ucq_overflow)
  );

  assign below_idx = sp_q[SP_W-2:0] - (SP_W-1)'(2);

  always_comb begin
    state_d    = state_q;
    lit_d      = lit_q;
    ack_mask_d = ack_mask_q;
    fifo_rd    = 1'b0;
    fifo_flush = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    case (state_q)
      UCA_IDLE: begin
        if (!halt) begin
          if (!fifo_empty) begin
            fifo_rd = 1'b1;
            lit_d   = fifo_head;
            state_d = UCA_CHECK;
          end else if (done_seen_q) begin
            state_d = UCA_DONE;
          end
        end
      end
      UCA_CHECK: begin
        if (lit_var(lit_q) == '0) begin
          state_d = UCA_IDLE;
        end else if (!assigned_q[lit_var(lit_q)]) begin
          push    = 1'b1;
          state_d = UCA_BCAST;
        end else if (value_q[lit_var(lit_q)] == lit_sign(lit_q)) begin
          state_d = UCA_IDLE;
        end else begin
          fifo_flush = 1'b1;
          state_d    = UCA_CONFLICT;
        end
      end
      UCA_BCAST: begin
        if ((ack_mask_q | eng_ack) == '1) begin
          ack_mask_d = '0;
          state_d    = UCA_IDLE;
        end else begin
          ack_mask_d = ack_mask_q | eng_ack;
        end
      end
      default: ;
    endcase
    // Pops are confined to states that never push, so the two cannot collide.
    if (mstack_pop && (sp_q != '0) &&
        (state_q == UCA_IDLE || state_q == UCA_CONFLICT || state_q == UCA_DONE))
      pop = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= UCA_IDLE;
      lit_q        <= '0;
      ack_mask_q   <= '0;
      done_seen_q  <= 1'b0;
      assigned_q   <= '0;
      value_q      <= '0;
      sp_q         <= '0;
      mstack_lit_q <= '0;
    end else begin
      state_q     <= state_d;
      lit_q       <= lit_d;
      ack_mask_q  <= ack_mask_d;
      done_seen_q <= done_seen_q | mem2uca_done;
      if (push) begin
        assigned_q[lit_var(lit_q)] <= 1'b1;
        value_q[lit_var(lit_q)]    <= lit_sign(lit_q);
        sp_q                       <= sp_q + SP_W'(1);
        mstack_lit_q               <= lit_q;
      end else if (pop) begin
        assigned_q[lit_var(mstack_lit_q)] <= 1'b0;
        sp_q                              <= sp_q - SP_W'(1);
        mstack_lit_q <= (sp_q > SP_W'(1)) ? stack_q[below_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q[SP_W-2:0]] <= lit_q;
  end

  assign bcast_valid  = (state_q == UCA_BCAST);
  assign bcast_lit    = bcast_valid ? lit_q : '0;
  assign conflict     = (state_q == UCA_CONFLICT);
  assign uca_done     = (state_q == UCA_DONE);
  assign mstack_empty = (sp_q == '0);
  assign mstack_lit   = mstack_lit_q;
endmodule

// File: tb/tb_uc_arbiter.sv
// Directed bench for uc_arbiter: latency, duplicates, conflicts, staggered
// acks, FIFO overflow, backtracking and mid-broadcast reset.
module tb_uc_arbiter;
  import sat_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  halt;
  lit_t                  mem2uca;
  logic                  mem2uca_valid;
  logic                  mem2uca_done;
  logic                  ucq_full;
  logic                  ucq_overflow;
  lit_t                  bcast_lit;
  logic                  bcast_valid;
  logic [NUM_ENGINE-1:0] eng_ack;
  logic                  conflict;
  logic                  uca_done;
  logic                  mstack_pop;
  logic                  mstack_empty;
  lit_t                  mstack_lit;

  int n_checks = 0;
  int n_errors = 0;

  uc_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .halt          (halt),
    .mem2uca       (mem2uca),
    .mem2uca_valid (mem2uca_valid),
    .mem2uca_done  (mem2uca_done),
    .ucq_full      (ucq_full),
    .ucq_overflow  (ucq_overflow),
    .bcast_lit     (bcast_lit),
    .bcast_valid   (bcast_valid),
    .eng_ack       (eng_ack),
    .conflict      (conflict),
    .uca_done      (uca_done),
    .mstack_pop    (mstack_pop),
    .mstack_empty  (mstack_empty),
    .mstack_lit    (mstack_lit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1; halt = 1'b0; mem2uca = '0; mem2uca_valid = 1'b0;
    mem2uca_done = 1'b0; eng_ack = '0; mstack_pop = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
  endtask

  task automatic push(input lit_t l);
    mem2uca = l; mem2uca_valid = 1'b1;
    tick();
    mem2uca_valid = 1'b0;
  endtask

  task automatic pop();
    mstack_pop = 1'b1;
    tick();
    mstack_pop = 1'b0;
  endtask

  task automatic wait_bcast(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bcast_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Waits for a broadcast, then pulses each engine's ack d[i] cycles after
  // bcast_valid first appears; checks hold and release of the broadcast.
  task automatic bcast(input string tag, input lit_t exp, input int d0, input int d1,
                       input int d2, input int d3);
    int d[4];
    int maxd;
    bit seen;
    d = '{d0, d1, d2, d3};
    maxd = 0;
    for (int i = 0; i < 4; i++) if (d[i] > maxd) maxd = d[i];
    wait_bcast(seen);
    check({tag, "_seen"}, {31'd0, seen}, 32'd1);
    if (!seen) return;
    check({tag, "_lit"}, {25'd0, bcast_lit}, {25'd0, exp});
    for (int k = 1; k <= maxd; k++) begin
      for (int i = 0; i < 4; i++) eng_ack[i] = (d[i] == k);
      if (k > 1) begin
        check({tag, "_hold_valid"}, {31'd0, bcast_valid}, 32'd1);
        check({tag, "_hold_lit"}, {25'd0, bcast_lit}, {25'd0, exp});
      end
      tick();
    end
    eng_ack = '0;
    check({tag, "_drop"}, {31'd0, bcast_valid}, 32'd0);
  endtask

  int  cnt;
  bit  seen;
  lit_t l;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    do_reset();
    rst_n = 1'b1;
    tick();
    check("rst_full",     {31'd0, ucq_full},     32'd0);
    check("rst_ovf",      {31'd0, ucq_overflow}, 32'd0);
    check("rst_bvalid",   {31'd0, bcast_valid},  32'd0);
    check("rst_blit",     {25'd0, bcast_lit},    32'd0);
    check("rst_conflict", {31'd0, conflict},     32'd0);
    check("rst_done",     {31'd0, uca_done},     32'd0);
    check("rst_empty",    {31'd0, mstack_empty}, 32'd1);
    check("rst_slit",     {25'd0, mstack_lit},   32'd0);
    rst_n = 1'b0;

    // Single literal: latency N+2, stack records it
    push(7'h05);
    check("lat_n0", {31'd0, bcast_valid}, 32'd0);
    tick();
    check("lat_n1", {31'd0, bcast_valid}, 32'd0);
    tick();
    check("lat_n2", {31'd0, bcast_valid}, 32'd1);
    bcast("b1", 7'h05, 1, 1, 1, 1);
    check("b1_slit",  {25'd0, mstack_lit},   32'h05);
    check("b1_empty", {31'd0, mstack_empty}, 32'd0);

    // Duplicate literal yields one broadcast and one stack entry
    do_reset();
    push(7'h05);
    push(7'h05);
    bcast("dup", 7'h05, 1, 1, 1, 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bcast_valid) cnt++;
      tick();
    end
    check("dup_nobcast", cnt, 0);
    pop();
    check("dup_pop_empty", {31'd0, mstack_empty}, 32'd1);
    check("dup_pop_lit",   {25'd0, mstack_lit},   32'd0);

    // Contradiction: sticky conflict, later literals ignored
    do_reset();
    push(7'h05);
    push(7'h45);
    bcast("cf", 7'h05, 1, 1, 1, 1);
    cnt = 0;
    for (int i = 0; i < 10 && !conflict; i++) begin
      if (bcast_valid) cnt++;
      tick();
    end
    check("cf_conflict", {31'd0, conflict}, 32'd1);
    check("cf_nobcast", cnt, 0);
    push(7'h09);
    push(7'h0A);
    mem2uca_done = 1'b1;
    tick();
    mem2uca_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bcast_valid) cnt++;
      tick();
    end
    check("cf_late_nobcast", cnt, 0);
    check("cf_held",   {31'd0, conflict},   32'd1);
    check("cf_nodone", {31'd0, uca_done},   32'd0);
    check("cf_slit",   {25'd0, mstack_lit}, 32'h05);

    // Staggered acks hold the broadcast for 5 cycles
    do_reset();
    push(7'h11);
    bcast("stag", 7'h11, 1, 3, 2, 5);
    check("stag_slit", {25'd0, mstack_lit}, 32'h11);

    // Reset during a broadcast aborts it
    push(7'h0A);
    wait_bcast(seen);
    check("mid_seen", {31'd0, seen}, 32'd1);
    rst_n = 1'b1;
    tick();
    check("mid_bvalid", {31'd0, bcast_valid},  32'd0);
    check("mid_empty",  {31'd0, mstack_empty}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_after", {31'd0, bcast_valid}, 32'd0);

    // Fill FIFO under halt, overflow, drain in order, then done
    do_reset();
    halt = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      l = lit_t'(((i % 2) << 6) | i);
      push(l);
    end
    check("fill_full", {31'd0, ucq_full},     32'd1);
    check("fill_ovf0", {31'd0, ucq_overflow}, 32'd0);
    check("fill_nob",  {31'd0, bcast_valid},  32'd0);
    push(7'h14);
    check("fill_ovf1", {31'd0, ucq_overflow}, 32'd1);
    halt = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      l = lit_t'(((i % 2) << 6) | i);
      bcast($sformatf("drain%0d", i), l, 1, 1, 1, 1);
    end
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bcast_valid) cnt++;
      tick();
    end
    check("drain_no9th", cnt, 0);
    check("drain_full",  {31'd0, ucq_full},   32'd0);
    check("drain_slit",  {25'd0, mstack_lit}, 32'h08);
    mem2uca_done = 1'b1;
    tick();
    mem2uca_done = 1'b0;
    for (int i = 0; i < 6 && !uca_done; i++) tick();
    check("drain_done",  {31'd0, uca_done},     32'd1);
    check("drain_ovfst", {31'd0, ucq_overflow}, 32'd1);

    // Backtrack: pop ~7, re-assign 7 positively without conflict
    do_reset();
    push(7'h03);
    bcast("bt3", 7'h03, 1, 1, 1, 1);
    push(7'h47);
    bcast("bt7", 7'h47, 2, 1, 1, 1);
    check("bt_top", {25'd0, mstack_lit}, 32'h47);
    pop();
    check("bt_pop_lit",   {25'd0, mstack_lit},   32'h03);
    check("bt_pop_empty", {31'd0, mstack_empty}, 32'd0);
    push(7'h07);
    bcast("bt7p", 7'h07, 1, 1, 1, 1);
    check("bt_noconf", {31'd0, conflict},   32'd0);
    check("bt_slit",   {25'd0, mstack_lit}, 32'h07);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uc_arbiter.md
Name: uc_arbiter

Overview:
- Unit-clause arbiter between the clause memory's unit-literal stream (mem2uca) and the NUM_ENGINE BCP engines.
- Buffers incoming unit literals and checks each against a per-variable assignment table.
- Broadcasts new assignments to all engines with a per-engine acknowledge, and records assignments on an assignment stack (mstack) for backtracking.
- Raises a sticky conflict when a literal contradicts an existing assignment.

Parameters:
- NUM_ENGINE, 4, number of BCP engines receiving broadcasts.
- NUM_VARS, 64, variable count; index 0 reserved/invalid.
- UCQ_DEPTH, 8, incoming literal FIFO depth (power of 2).
- STACK_DEPTH, 64, assignment stack depth (>= NUM_VARS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Synchronous, active-high: 1 = reset.
- halt  in  1  1 = FSM holds in IDLE; FIFO still accepts.
- mem2uca  in  LIT_W  unit literal {sign, var}.
- mem2uca_valid  in  1  literal valid.
- mem2uca_done  in  1  1-cycle pulse: no more literals this round.
- ucq_full  out  1  FIFO full; producer must not assert valid.
- ucq_overflow  out  1  sticky: valid seen while full (literal dropped).
- bcast_lit  out  LIT_W  literal broadcast to engines.
- bcast_valid  out  1  broadcast valid.
- eng_ack  in  NUM_ENGINE  per-engine acknowledge, 1-cycle pulses.
- conflict  out  1  sticky contradiction flag.
- uca_done  out  1  round complete, no conflict.
- mstack_pop  in  1  pop top assignment (backtrack).
- mstack_empty  out  1  stack empty.
- mstack_lit  out  LIT_W  top-of-stack literal (0 when empty).

Behaviour:
- Reset outputs: ucq_full=0, ucq_overflow=0, bcast_valid=0, bcast_lit=0, conflict=0, uca_done=0, mstack_empty=1, mstack_lit=0.
- Reset also clears the FIFO, assignment table, stack, ack mask and done_seen.
- Reset asserted mid-operation aborts everything on that edge; no partial broadcast survives.
- FIFO accept: mem2uca_valid && !ucq_full enqueues at the edge.
  - valid && full: literal dropped, ucq_overflow set (sticky until reset).
- done_seen: set by mem2uca_done, cleared by reset.
- Assignment table: {assigned, value} per variable.
- FSM states: IDLE, CHECK, BCAST, CONFLICT, DONE.
- IDLE:
  - !halt && FIFO non-empty: dequeue head into lit_r, go to CHECK.
  - else if FIFO empty && done_seen: go to DONE.
- CHECK (1 cycle), by table lookup on lit_r:
  - var==0: discard, go to IDLE.
  - Unassigned: write table, push lit_r onto stack, go to BCAST.
  - Assigned, same sign: duplicate; discard, go to IDLE.
  - Assigned, opposite sign: set conflict, flush FIFO, go to CONFLICT.
- BCAST:
  - bcast_valid=1 and bcast_lit=lit_r, both held stable.
  - ack_mask |= eng_ack each cycle.
  - When (ack_mask | eng_ack) is all ones: clear mask, go to IDLE; bcast_valid drops on the next cycle.
  - Acks arriving outside BCAST are ignored.
- CONFLICT: terminal until reset; conflict=1. FIFO input is still counted for ucq_overflow but literals are discarded.
- DONE: uca_done=1 until reset.
- Latency: literal accepted at edge N into an empty FIFO with FSM in IDLE gives CHECK at N+1 and bcast_valid high at N+2.
- Stack:
  - Push occurs only in CHECK.
  - mstack_pop is honoured only in IDLE, CONFLICT or DONE; ignored in CHECK/BCAST, so push and pop never collide.
  - Pop when empty is ignored.
  - A pop clears the assigned bit of the popped variable.
  - mstack_lit is registered and updates the same edge as the push/pop.
  - Push when full is impossible because STACK_DEPTH >= NUM_VARS and each variable is pushed at most once.
- Width rules:
  - VAR_W = clog2(NUM_VARS); LIT_W = VAR_W+1; sign is the MSB, 1 = negated.
  - FIFO pointers are clog2(UCQ_DEPTH)+1 bits (wrap bit for full/empty).

Decomposition:
- sat_pkg holds lit_t, LIT_W, VAR_W, NUM_ENGINE, and helpers lit_var()/lit_sign().
- uca_state_e is declared in sat_pkg.
- One sub-module: uc_fifo (parameterised sync FIFO with full/empty/overflow).
- Table and stack stay inline.

Test Plan:
- Reset then push lit {0,5} with all engines acking after 1 cycle -> bcast_valid at N+2 with bcast_lit={0,5}; mstack_lit={0,5}; mstack_empty=0.
- Push {0,5} then {0,5} -> exactly one broadcast; stack depth 1.
- Push {0,5} then {1,5} -> conflict=1 after CHECK of the second literal, no second broadcast; later literals discarded; conflict held until reset.
- Engines ack staggered over cycles 1, 3, 2, 5 -> bcast_valid held 5 cycles with lit stable, then drops.
- Fill 8 literals while halt=1, push a 9th -> ucq_full=1 and ucq_overflow=1; release halt -> 8 broadcasts in FIFO order; mem2uca_done -> uca_done=1.
- After assigning {0,3} and {1,7}, pulse mstack_pop in IDLE -> mstack_lit={0,3}; re-push {0,7} -> accepted and broadcast, no conflict.
